xrv_lsu: RTL and testbench
==========================

// Module: xrv_lsu
// PURPOSE
//  Parametrised load/store unit placed between the execute stage and the data bus.
//  Stores are posted into a SB_DEPTH-entry store buffer and drained in order.
//  Loads wait until the buffer is empty, then return sign/zero-extended writeback data.
//  Optional split of misaligned accesses into two aligned bus beats.
// PARAMETERS
//  SB_DEPTH  4   store-buffer entries; power of two, >=2
//  ADDR_W    32  byte-address width; bus data fixed at 32 bits, 4 byte lanes
// PORTS
//  clk          in   1       clock
//  rstb         in   1       reset, asynchronous, active-low
//  req_valid    in   1       access request from EX
//  req_ready    out  1       request accepted when valid&ready
//  req_load     in   1       1=load, 0=store; stable while req_valid
//  req_funct3   in   3       RV32 LB/LH/LW/LBU/LHU, SB/SH/SW encoding
//  req_addr     in   ADDR_W  effective byte address (rs1+imm)
//  req_wdata    in   32      store data, LSB-aligned
//  req_rd       in   5       load destination register
//  rsp_valid    out  1       1-cycle pulse: load done, or error
//  rsp_rd       out  5       destination of the completed load
//  rsp_data     out  32      extended load data
//  rsp_err      out  1       misaligned access rejected (macro off only)
//  sb_empty     out  1       buffer empty and bus idle (used by FENCE)
//  d_addr       out  ADDR_W  word-aligned bus address ([1:0]=0)
//  d_be         out  4       byte enables
//  d_wr_req     out  1       write request, held until d_wr_ready
//  d_wr_data    out  32      lane-positioned write data
//  d_wr_ready   in   1       write accepted
//  d_rd_req     out  1       read request, held until d_rd_ready
//  d_rd_ready   in   1       read data valid on d_rd_data
//  d_rd_data    in   32      read data
// BEHAVIOUR
//  Reset values: all outputs 0 except sb_empty=1. Buffer pointers cleared, FSM to IDLE.
//  Reset mid-transfer abandons the transfer; no retry is issued afterwards.
//  req_ready for a store = (count<SB_DEPTH); uses the count before this cycle's dequeue.
//  req_ready for a load  = (count==0) & IDLE & ~ld_pend.
//  Store accept: lanes and BE are computed and pushed in the same cycle; no rsp is produced.
//  Lane/BE rules:
//   - byte: BE=1<<a[1:0]
//   - half: BE=a[1]?C:3
//   - word: BE=F
//   - data shifted by 8*a[1:0]
//  Bus FSM, one transaction at a time; requests are registered outputs.
//   IDLE : if count>0, pop head -> WR (d_wr_req=1).
//          Else if ld_pend -> RD (d_rd_req=1).
//          Stores take priority over the pending load.
//   WR   : on d_wr_ready: split? -> WR2 : IDLE. Req drops the cycle after ready.
//   WR2  : second beat at d_addr+4 with the high lanes; on d_wr_ready -> IDLE.
//   RD   : on d_rd_ready: latch data; split? -> RD2 : RSP.
//   RD2  : second beat, merge high lanes; on d_rd_ready -> RSP.
//   RSP  : rsp_valid=1 for one cycle with rsp_rd/rsp_data -> IDLE.
//  Load latency with zero-wait bus: accept T, d_rd_req T+1, ready T+1, rsp_valid T+2.
//  Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
//   Unknown funct3 returns 0.
//  ready is sampled only while req is high. A ready arriving in the same cycle the
//   FSM asserts req is honoured.
//  Buffer pointers wrap modulo SB_DEPTH. Enqueue and dequeue in the same cycle keep count.
//  Second-beat address wraps modulo 2^ADDR_W: FFFF_FFFC -> 0000_0000.
//  sb_empty = (count==0) & IDLE & ~ld_pend.
// CONFIGURATION
//  XRV_LSU_MISALIGN_EN defined:
//   - half with a[0]=1, or word with a[1:0]!=0 and a span crossing a word, splits into two beats.
//   - rsp_err is tied 0.
//  Undefined:
//   - misaligned request is accepted but never reaches the bus or the buffer.
//   - next cycle: rsp_valid=1, rsp_err=1, rsp_data=0; for a store, rsp_rd=0.
//   - WR2/RD2 are not built.
// TESTING
//  SW x=A5A5_1234 @0x100, zero-wait -> d_addr=0x100 BE=F data=A5A5_1234, one write.
//  LB @0x103, bus word 80xx_xxxx -> rsp_data=FFFF_FF80; LBU same -> 0000_0080; rsp 2 cycles after accept.
//  SB_DEPTH+1 stores with d_wr_ready held 0 -> req_ready low on the 5th; then LW stalls until 4 writes drain in order.
//  Macro on, LW @0x102 reads 0x100=4433_2211, 0x104=8877_6655 -> two reads BE=C,3, rsp_data=6655_4433.
//  Macro off, SH @0x101 -> rsp_err pulse, no d_wr_req, sb_empty stays 1.
//  rstb low during RD with d_rd_req=1 -> d_rd_req=0 immediately, no rsp_valid after release.

Source files
------------

// File: rtl/xrv_lsu.sv
// xrv_lsu: load/store unit with an in-order posted store buffer in front of a 32-bit data bus.
// Build option XRV_LSU_MISALIGN_EN splits word-crossing accesses into two aligned beats.
module xrv_lsu #(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [4:0]        rsp_rd,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic              sb_empty,
    output logic [ADDR_W-1:0] d_addr,
    output logic [3:0]        d_be,
    output logic              d_wr_req,
    output logic [31:0]       d_wr_data,
    input  logic              d_wr_ready,
    output logic              d_rd_req,
    input  logic              d_rd_ready,
    input  logic [31:0]       d_rd_data
);
    localparam int          PW      = $clog2(SB_DEPTH);
    localparam logic [PW:0] SB_FULL = (PW+1)'(SB_DEPTH);

    // IDLE pick work | WR/WR2 write beats | RD/RD2 read beats | RSP load response
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR2, S_RD, S_RD2, S_RSP} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be_lo;
        logic [3:0]        be_hi;
        logic [31:0]       data_lo;
        logic [31:0]       data_hi;
        logic              split;
    } sb_entry_t;

    state_t            state, state_nxt;
    sb_entry_t         sb_mem [SB_DEPTH];
    sb_entry_t         head, new_entry;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [7:0]        size_mask, lane_mask;
    logic [63:0]       lane_data;
    logic              mis_raw, err_trig, req_split;
    logic              ld_ready, st_ready, fire, ld_fire, enq, deq;
    logic              ld_pend, split_q, err_q;
    logic [4:0]        ld_rd, err_rd;
    logic [2:0]        ld_f3;
    logic [1:0]        ld_off;
    logic [3:0]        hi_be;
    logic [31:0]       hi_data, rd_lo, rd_hi, ld_word, ld_ext;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'h00;
        endcase
    end

    assign lane_mask = size_mask << req_addr[1:0];
    assign lane_data = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    assign mis_raw   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                       (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);

`ifdef XRV_LSU_MISALIGN_EN
    assign err_trig  = 1'b0;
    assign req_split = mis_raw & (|lane_mask[7:4]);
`else
    assign err_trig  = mis_raw;
    assign req_split = 1'b0;
`endif

    // A rejected store is held off while a load is in flight so the two responses never collide.
    assign ld_ready  = (count == '0) && (state == S_IDLE) && !ld_pend;
    assign st_ready  = (count < SB_FULL) && !(err_trig && ld_pend);
    assign req_ready = req_load ? ld_ready : st_ready;
    assign fire      = req_valid && req_ready;
    assign ld_fire   = fire && req_load && !err_trig;
    assign enq       = fire && !req_load && !err_trig;
    assign deq       = d_wr_ready && ((state == S_WR && !split_q) || state == S_WR2);

    assign head      = sb_mem[rd_ptr];
    assign new_entry = '{addr: {req_addr[ADDR_W-1:2], 2'b00}, be_lo: lane_mask[3:0],
                         be_hi: lane_mask[7:4], data_lo: lane_data[31:0],
                         data_hi: lane_data[63:32], split: req_split};

    always_ff @(posedge clk) begin
        if (enq) sb_mem[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (count != '0)             state_nxt = S_WR;
                    else if (ld_pend || ld_fire) state_nxt = S_RD;
            S_WR:   if (d_wr_ready)              state_nxt = split_q ? S_WR2 : S_IDLE;
            S_WR2:  if (d_wr_ready)              state_nxt = S_IDLE;
            S_RD:   if (d_rd_ready)              state_nxt = split_q ? S_RD2 : S_RSP;
            S_RD2:  if (d_rd_ready)              state_nxt = S_RSP;
            S_RSP:                               state_nxt = S_IDLE;
            default:                             state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ld_pend   <= 1'b0;
            ld_rd     <= '0;
            ld_f3     <= '0;
            ld_off    <= '0;
            split_q   <= 1'b0;
            hi_be     <= '0;
            hi_data   <= '0;
            d_addr    <= '0;
            d_be      <= '0;
            d_wr_data <= '0;
            rd_lo     <= '0;
            rd_hi     <= '0;
            err_q     <= 1'b0;
            err_rd    <= '0;
        end else begin
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;

            err_q <= fire && err_trig;
            if (fire && err_trig) err_rd <= req_load ? req_rd : 5'd0;

            if (ld_fire) begin
                ld_pend <= 1'b1;
                ld_rd   <= req_rd;
                ld_f3   <= req_funct3;
                ld_off  <= req_addr[1:0];
            end else if (state == S_RSP) begin
                ld_pend <= 1'b0;
            end

            if (state == S_IDLE && state_nxt == S_WR) begin
                d_addr    <= head.addr;
                d_be      <= head.be_lo;
                d_wr_data <= head.data_lo;
                hi_be     <= head.be_hi;
                hi_data   <= head.data_hi;
                split_q   <= head.split;
            end else if (state == S_IDLE && state_nxt == S_RD) begin
                d_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                d_be    <= lane_mask[3:0];
                hi_be   <= lane_mask[7:4];
                split_q <= req_split;
                rd_hi   <= '0;
            end else if ((state == S_WR && state_nxt == S_WR2) ||
                         (state == S_RD && state_nxt == S_RD2)) begin
                d_addr    <= d_addr + ADDR_W'(4);
                d_be      <= hi_be;
                d_wr_data <= hi_data;
            end

            if (state == S_RD && d_rd_ready)  rd_lo <= d_rd_data;
            if (state == S_RD2 && d_rd_ready) rd_hi <= d_rd_data;
        end
    end

    assign ld_word = 32'({rd_hi, rd_lo} >> {ld_off, 3'b000});

    always_comb begin
        case (ld_f3)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b010:  ld_ext = ld_word;
            3'b100:  ld_ext = {24'h0, ld_word[7:0]};
            3'b101:  ld_ext = {16'h0, ld_word[15:0]};
            default: ld_ext = 32'h0;
        endcase
    end

    always_comb begin
        d_wr_req  = 1'b0;
        d_rd_req  = 1'b0;
        rsp_valid = 1'b0;
        rsp_rd    = 5'd0;
        rsp_data  = 32'h0;
        rsp_err   = err_q;
        sb_empty  = (count == '0) && (state == S_IDLE) && !ld_pend;
        case (state)
            S_WR, S_WR2: d_wr_req = 1'b1;
            S_RD, S_RD2: d_rd_req = 1'b1;
            S_RSP: begin
                rsp_valid = 1'b1;
                rsp_rd    = ld_rd;
                rsp_data  = ld_ext;
            end
            default: ;
        endcase
        if (err_q) begin
            rsp_valid = 1'b1;
            rsp_rd    = err_rd;
        end
    end

endmodule

// File: tb/tb_xrv_lsu.sv
// Self-checking bench for xrv_lsu: vector table plus hand-written stall, latency and reset sequences.
module tb_xrv_lsu;
    logic        clk = 1'b0;
    logic        rstb;
    logic        req_valid, req_ready, req_load;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid, rsp_err, sb_empty;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_data;
    logic [31:0] d_addr, d_wr_data, d_rd_data;
    logic [3:0]  d_be;
    logic        d_wr_req, d_wr_ready, d_rd_req, d_rd_ready;

    always #5 clk = ~clk;

    xrv_lsu #(.SB_DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .sb_empty(sb_empty), .d_addr(d_addr), .d_be(d_be),
        .d_wr_req(d_wr_req), .d_wr_data(d_wr_data), .d_wr_ready(d_wr_ready),
        .d_rd_req(d_rd_req), .d_rd_ready(d_rd_ready), .d_rd_data(d_rd_data)
    );

    typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] data; } wr_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; logic err; } rsp_t;
    typedef struct {
        logic ld; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata; logic [4:0] rd;
        logic [3:0] exp_be; logic [31:0] exp_data; logic [4:0] exp_rd; logic err;
    } vec_t;

    wr_t         wr_q[$];
    rsp_t        rsp_q[$];
    logic [3:0]  rdbe_q[$];
    vec_t        tv[$];
    logic [31:0] mem [256];
    int          n_vec = 0, n_err = 0, cyc = 0, acc_cyc = 0, last_rsp_cyc = 0;

    assign d_rd_data = mem[d_addr[9:2]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    rsp_t mr;
    wr_t  mw;
    always begin
        @(negedge clk);
        #3;
        if (rstb) begin
            if (rsp_valid) begin
                last_rsp_cyc = cyc;
                if (rsp_q.size() == 0) flag("unexpected_rsp");
                else begin
                    mr = rsp_q.pop_front();
                    chk("rsp_rd", 32'(rsp_rd), 32'(mr.rd));
                    chk("rsp_data", rsp_data, mr.data);
                    chk("rsp_err", 32'(rsp_err), 32'(mr.err));
                    if (!mr.err) chk("ld_after_drain", 32'(wr_q.size()), 32'd0);
                end
            end
            if (d_wr_req && d_wr_ready) begin
                if (wr_q.size() == 0) flag("unexpected_write");
                else begin
                    mw = wr_q.pop_front();
                    chk("wr_addr", d_addr, mw.addr);
                    chk("wr_be", 32'(d_be), 32'(mw.be));
                    chk("wr_data", d_wr_data, mw.data);
                end
            end
            if (d_rd_req && d_rd_ready && rdbe_q.size() > 0)
                chk("rd_be", 32'(d_be), 32'(rdbe_q.pop_front()));
        end
    end

    task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        int t;
        @(negedge clk);
        req_valid = 1'b1; req_load = ld; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        #1;
        t = 0;
        while (!req_ready && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (!req_ready) begin
            flag("issue_timeout");
            req_valid = 1'b0;
        end else begin
            acc_cyc = cyc;
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(negedge clk); #4; t++;
        end while (!(rsp_q.size() == 0 && wr_q.size() == 0 && sb_empty) && t < 100);
        if (t >= 100) flag("drain_timeout");
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_q.push_back('{addr: a, be: be, data: d});
    endtask

    task automatic push_rsp(input logic [4:0] rd, input logic [31:0] d, input logic e);
        rsp_q.push_back('{rd: rd, data: d, err: e});
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rstb = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        d_wr_ready = 1'b1; d_rd_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h80] = 32'h8012_3456;
        mem[8'h40] = 32'h80AB_CDEF;
        mem[8'h04] = 32'h0BAD_F00D;

        // ld f3 addr wdata rd | exp_be exp_data exp_rd err
        tv.push_back('{1'b0, 3'b010, 32'h100, 32'hA5A5_1234, 5'd0, 4'hF, 32'hA5A5_1234, 5'd0, 1'b0});
        tv.push_back('{1'b0, 3'b000, 32'h101, 32'h0000_00AB, 5'd0, 4'h2, 32'h0000_AB00, 5'd0, 1'b0});
        tv.push_back('{1'b0, 3'b001, 32'h102, 32'h0000_BEEF, 5'd0, 4'hC, 32'hBEEF_0000, 5'd0, 1'b0});
        tv.push_back('{1'b0, 3'b000, 32'h103, 32'h0000_0012, 5'd0, 4'h8, 32'h1200_0000, 5'd0, 1'b0});
        tv.push_back('{1'b0, 3'b001, 32'h100, 32'h0000_CAFE, 5'd0, 4'h3, 32'h0000_CAFE, 5'd0, 1'b0});
        tv.push_back('{1'b0, 3'b010, 32'hFFFF_FFF0, 32'hDEAD_BEEF, 5'd0, 4'hF, 32'hDEAD_BEEF, 5'd0, 1'b0});
        tv.push_back('{1'b1, 3'b000, 32'h203, 32'h0, 5'd1,  4'h0, 32'hFFFF_FF80, 5'd1,  1'b0});
        tv.push_back('{1'b1, 3'b100, 32'h203, 32'h0, 5'd2,  4'h0, 32'h0000_0080, 5'd2,  1'b0});
        tv.push_back('{1'b1, 3'b001, 32'h202, 32'h0, 5'd3,  4'h0, 32'hFFFF_8012, 5'd3,  1'b0});
        tv.push_back('{1'b1, 3'b101, 32'h202, 32'h0, 5'd4,  4'h0, 32'h0000_8012, 5'd4,  1'b0});
        tv.push_back('{1'b1, 3'b010, 32'h200, 32'h0, 5'd5,  4'h0, 32'h8012_3456, 5'd5,  1'b0});
        tv.push_back('{1'b1, 3'b000, 32'h200, 32'h0, 5'd6,  4'h0, 32'h0000_0056, 5'd6,  1'b0});
        tv.push_back('{1'b1, 3'b001, 32'h200, 32'h0, 5'd7,  4'h0, 32'h0000_3456, 5'd7,  1'b0});
        tv.push_back('{1'b1, 3'b000, 32'h201, 32'h0, 5'd8,  4'h0, 32'h0000_0034, 5'd8,  1'b0});
        tv.push_back('{1'b1, 3'b100, 32'h202, 32'h0, 5'd9,  4'h0, 32'h0000_0012, 5'd9,  1'b0});
        tv.push_back('{1'b1, 3'b011, 32'h200, 32'h0, 5'd10, 4'h0, 32'h0000_0000, 5'd10, 1'b0});
        tv.push_back('{1'b1, 3'b110, 32'h200, 32'h0, 5'd11, 4'h0, 32'h0000_0000, 5'd11, 1'b0});
`ifndef XRV_LSU_MISALIGN_EN
        tv.push_back('{1'b0, 3'b001, 32'h101, 32'h1234, 5'd9, 4'h0, 32'h0, 5'd0, 1'b1});
        tv.push_back('{1'b0, 3'b010, 32'h203, 32'h5678, 5'd4, 4'h0, 32'h0, 5'd0, 1'b1});
        tv.push_back('{1'b1, 3'b010, 32'h102, 32'h0,    5'd7, 4'h0, 32'h0, 5'd7, 1'b1});
        tv.push_back('{1'b1, 3'b101, 32'h203, 32'h0,    5'd3, 4'h0, 32'h0, 5'd3, 1'b1});
`endif

        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_d_wr_req", 32'(d_wr_req), 32'd0);
        chk("rst_d_rd_req", 32'(d_rd_req), 32'd0);
        chk("rst_d_be", 32'(d_be), 32'd0);
        chk("rst_d_addr", d_addr, 32'd0);
        chk("rst_sb_empty", 32'(sb_empty), 32'd1);
        rstb = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            issue(tv[i].ld, tv[i].f3, tv[i].addr, tv[i].wdata, tv[i].rd);
            if (tv[i].ld || tv[i].err) push_rsp(tv[i].exp_rd, tv[i].exp_data, tv[i].err);
            else push_wr({tv[i].addr[31:2], 2'b00}, tv[i].exp_be, tv[i].exp_data);
            drain();
        end

        // load latency on a zero-wait bus, sign and zero extension of the top byte
        issue(1'b1, 3'b000, 32'h103, 32'h0, 5'd17);
        push_rsp(5'd17, 32'hFFFF_FF80, 1'b0);
        #1;
        chk("rd_req_t1", 32'(d_rd_req), 32'd1);
        drain();
        chk("ld_latency", 32'(last_rsp_cyc - acc_cyc), 32'd2);
        issue(1'b1, 3'b100, 32'h103, 32'h0, 5'd18);
        push_rsp(5'd18, 32'h0000_0080, 1'b0);
        drain();

        // full buffer with a stalled bus, then a load that must wait for the drain
        d_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 3'b010, 32'h10 + 32'(4 * i), 32'h1111_0000 + 32'(i), 5'd0);
            push_wr(32'h10 + 32'(4 * i), 4'hF, 32'h1111_0000 + 32'(i));
        end
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("full_sb_empty", 32'(sb_empty), 32'd0);
        fork
            begin
                issue(1'b1, 3'b010, 32'h10, 32'h0, 5'd12);
                push_rsp(5'd12, 32'h0BAD_F00D, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                #1;
                chk("ld_stall_ready", 32'(req_ready), 32'd0);
                @(negedge clk);
                d_wr_ready = 1'b1;
            end
        join
        drain();

        // back-to-back stores so enqueue and dequeue overlap and pointers wrap
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 3'b000, 32'h20 + 32'(i), 32'(8'hC0 + i), 5'd0);
            push_wr(32'h20 + 32'(i & 4), 4'(1 << (i % 4)), 32'(8'hC0 + i) << (8 * (i % 4)));
        end
        drain();

`ifdef XRV_LSU_MISALIGN_EN
        mem[8'h40] = 32'h4433_2211;
        mem[8'h41] = 32'h8877_6655;
        rdbe_q.push_back(4'hC);
        rdbe_q.push_back(4'h3);
        issue(1'b1, 3'b010, 32'h102, 32'h0, 5'd20);
        push_rsp(5'd20, 32'h6655_4433, 1'b0);
        drain();
        chk("split_rd_beats", 32'(rdbe_q.size()), 32'd0);
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'hAABB_CCDD, 5'd0);
        push_wr(32'hFFFF_FFFC, 4'hC, 32'hCCDD_0000);
        push_wr(32'h0000_0000, 4'h3, 32'h0000_AABB);
        drain();
`else
        issue(1'b0, 3'b001, 32'h101, 32'h0000_BEEF, 5'd0);
        push_rsp(5'd0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #4;
            chk("mis_sb_empty", 32'(sb_empty), 32'd1);
            chk("mis_no_wr", 32'(d_wr_req), 32'd0);
            @(negedge clk);
        end
        drain();
`endif

        // reset while a read is outstanding abandons it
        d_rd_ready = 1'b0;
        issue(1'b1, 3'b010, 32'h200, 32'h0, 5'd13);
        #1;
        chk("rst_mid_rd_req", 32'(d_rd_req), 32'd1);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        chk("rst_drop_rd_req", 32'(d_rd_req), 32'd0);
        rsp_q.delete();
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        d_rd_ready = 1'b1;
        repeat (10) @(negedge clk);
        #4;
        chk("rst_after_sb_empty", 32'(sb_empty), 32'd1);
        chk("rst_after_no_rd", 32'(d_rd_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
